// File: rtl/spart_driver.sv
// Bus master for one spart: programs the baud divisor selected by i_br_cfg,
// then echoes received bytes back to the transmitter through a small FIFO.
module spart_driver #(
  parameter logic [15:0] DIV0  = 16'd650,
  parameter logic [15:0] DIV1  = 16'd325,
  parameter logic [15:0] DIV2  = 16'd162,
  parameter logic [15:0] DIV3  = 16'd80,
  parameter int          DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 i_br_cfg,
  input  logic                       i_rda,
  input  logic                       i_tbr,
  output logic                       o_iocs,
  output logic                       o_iorw,
  output logic [1:0]                 o_ioaddr,
  inout  wire  [7:0]                 io_databus,
  output logic [$clog2(DEPTH):0]     o_fifo_count,
  output logic                       o_cfg_done,
  output logic [1:0]                 o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    CFG_LO = 2'd0,
    CFG_HI = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_br_latch;
  logic        r_iocs;
  logic        r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_count;
  logic        r_cfg_done;

  logic [15:0] w_div;
  logic        w_rd_done;
  logic        w_wr_done;
  logic        w_hi_done;
  logic [AW:0] w_count_nx;
  logic        w_full_nx;
  logic        w_empty_nx;
  logic [7:0]  w_head;
  logic        w_rx_go;
  logic        w_tx_go;

  // Bus protocol: the registers describe the access of the current cycle; it
  // completes (read data captured, FIFO pushed/popped) at the posedge ending it,
  // and that same edge registers the access for the following cycle.
  always_comb begin
    w_div = DIV0;
    case (r_br_latch)
      2'b00:   w_div = DIV0;
      2'b01:   w_div = DIV1;
      2'b10:   w_div = DIV2;
      default: w_div = DIV3;
    endcase
  end

  assign w_rd_done = r_iocs &  r_iorw & (r_ioaddr == 2'b00);
  assign w_wr_done = r_iocs & ~r_iorw & (r_ioaddr == 2'b00);
  assign w_hi_done = r_iocs & ~r_iorw & (r_ioaddr == 2'b11);

  always_comb begin
    w_count_nx = r_count;
    if (w_rd_done)
      w_count_nx = r_count + 1'b1;
    else if (w_wr_done)
      w_count_nx = r_count - 1'b1;
  end

  assign w_full_nx  = (w_count_nx == FULL_CNT);
  assign w_empty_nx = (w_count_nx == '0);

  // An empty FIFO that is being pushed this edge forwards the byte on the bus.
  assign w_head = (r_count == '0) ? io_databus : r_mem[r_rd_ptr[AW-1:0]];

  // A completing access of one type is the holdoff for the next of that type.
  assign w_rx_go = i_rda & ~w_full_nx  & ~w_rd_done;
  assign w_tx_go = i_tbr & ~w_empty_nx & ~w_wr_done;

  always_ff @(posedge clk) begin
    if (w_rd_done)
      r_mem[r_wr_ptr[AW-1:0]] <= io_databus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= CFG_LO;
      r_br_latch <= i_br_cfg;
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b1;
      r_ioaddr   <= 2'b00;
      r_wdata    <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= 2'b00;
      r_count  <= w_count_nx;
      if (w_rd_done)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_wr_done)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_hi_done)
        r_cfg_done <= 1'b1;
      case (r_state)
        CFG_LO: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b10;
          r_wdata  <= w_div[7:0];
          r_state  <= CFG_HI;
        end
        CFG_HI: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b11;
          r_wdata  <= w_div[15:8];
          r_state  <= RUN;
        end
        RUN: begin
          if (i_br_cfg != r_br_latch) begin
            r_br_latch <= i_br_cfg;
            r_cfg_done <= 1'b0;
            r_state    <= CFG_LO;
          end else if (w_rx_go) begin
            r_iocs <= 1'b1;
          end else if (w_tx_go) begin
            r_iocs  <= 1'b1;
            r_iorw  <= 1'b0;
            r_wdata <= w_head;
          end
        end
        default: r_state <= CFG_LO;
      endcase
    end
  end

  assign io_databus   = (r_iocs && !r_iorw) ? r_wdata : 8'bz;
  assign o_iocs       = r_iocs;
  assign o_iorw       = r_iorw;
  assign o_ioaddr     = r_ioaddr;
  assign o_fifo_count = r_count;
  assign o_cfg_done   = r_cfg_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a behavioural spart feeds bytes and observes every bus
// access; echoed bytes are checked against a scoreboard queue.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic [7:0] bus_val = 8'h00;
  wire        iocs;
  wire        iorw;
  wire [1:0]  ioaddr;
  wire [7:0]  databus;
  wire [2:0]  fifo_count;
  wire        cfg_done;
  wire [1:0]  state;

  int total = 0;
  int bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [10:0] acc_log[$];
  logic        prev_rd = 1'b0;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;
  vec_t vecs[4];

  spart_driver dut (
    .clk(clk), .rst(rst), .i_br_cfg(br_cfg), .i_rda(rda), .i_tbr(tbr),
    .o_iocs(iocs), .o_iorw(iorw), .o_ioaddr(ioaddr), .io_databus(databus),
    .o_fifo_count(fifo_count), .o_cfg_done(cfg_done), .o_state(state)
  );

  assign databus = (iocs && iorw) ? bus_val : 8'bz;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Spart model and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (iocs) begin
        check("no_status_addr", {31'd0, ioaddr == 2'b01}, 32'd0);
        if (iorw) begin
          check("read_addr", {30'd0, ioaddr}, 32'd0);
          check("no_b2b_read", {31'd0, prev_rd}, 32'd0);
          if (rx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL read_without_data: read issued with rda low");
          end else begin
            bus_val = rx_q.pop_front();
          end
          acc_log.push_back({1'b1, ioaddr, bus_val});
        end else begin
          acc_log.push_back({1'b0, ioaddr, databus});
          if (ioaddr == 2'b00) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL echo_unexpected: got %0h want none", databus);
            end else begin
              check("echo_data", {24'd0, databus}, {24'd0, exp_q.pop_front()});
            end
          end
        end
      end
      prev_rd = iocs & iorw;
    end else begin
      prev_rd = 1'b0;
    end
    rda = (rx_q.size() != 0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_cfg(input logic v, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk); #1;
      if (cfg_done === v) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: cfg_done never reached %0d within 60 cycles", nm, v);
    end
  endtask

  task automatic wait_log(input int n, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk); #1;
      if (acc_log.size() >= n) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d accesses want %0d", nm, acc_log.size(), n);
    end
  endtask

  task automatic check_log(input int idx, input logic rw, input logic [1:0] a,
                           input logic [7:0] d, input string nm);
    if (idx < acc_log.size())
      check(nm, {21'd0, acc_log[idx]}, {21'd0, rw, a, d});
    else begin
      total++; bad++;
      $display("FAIL %s: access %0d missing want %0h", nm, idx, {rw, a, d});
    end
  endtask

  initial begin
    vecs[0] = '{cfg: 2'b11, lo: 8'h50, hi: 8'h00};
    vecs[1] = '{cfg: 2'b00, lo: 8'h8A, hi: 8'h02};
    vecs[2] = '{cfg: 2'b10, lo: 8'hA2, hi: 8'h00};
    vecs[3] = '{cfg: 2'b01, lo: 8'h45, hi: 8'h01};

    // T1: reset values and the initial divisor program for br_cfg=01
    step(3);
    check("rst_iocs", {31'd0, iocs}, 32'd0);
    check("rst_iorw", {31'd0, iorw}, 32'd1);
    check("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    acc_log.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_cfg(1'b1, "t1_cfg_done");
    check_log(0, 1'b0, 2'b10, 8'h45, "t1_lo");
    check_log(1, 1'b0, 2'b11, 8'h01, "t1_hi");
    step(5);
    check("t1_idle", acc_log.size(), 32'd2);

    // Divisor table: each br_cfg change reprograms both bytes
    for (int i = 0; i < 4; i++) begin
      step(1);
      acc_log.delete();
      br_cfg = vecs[i].cfg;
      wait_cfg(1'b0, "tbl_cfg_drop");
      wait_cfg(1'b1, "tbl_cfg_done");
      check("tbl_count", acc_log.size(), 32'd2);
      check_log(0, 1'b0, 2'b10, vecs[i].lo, "tbl_lo");
      check_log(1, 1'b0, 2'b11, vecs[i].hi, "tbl_hi");
    end

    // T2: single byte echoed
    step(1);
    acc_log.delete();
    tbr = 1'b1;
    push_rx(8'h41);
    wait_log(1, "t2_read");
    check_log(0, 1'b1, 2'b00, 8'h41, "t2_read");
    @(negedge clk); #1;
    check("t2_tx_iocs", {31'd0, iocs}, 32'd1);
    check("t2_tx_iorw", {31'd0, iorw}, 32'd0);
    check("t2_tx_data", {24'd0, databus}, 32'h41);
    check("t2_count1", {29'd0, fifo_count}, 32'd1);
    @(negedge clk); #1;
    check("t2_count0", {29'd0, fifo_count}, 32'd0);

    // T3: FIFO fills to 4 with tbr low, fifth byte waits in the spart
    tbr = 1'b0;
    step(1);
    acc_log.delete();
    for (int b = 0; b < 5; b++) push_rx(8'h10 + 8'(b));
    step(20);
    check("t3_reads", acc_log.size(), 32'd4);
    check("t3_full", {29'd0, fifo_count}, 32'd4);
    for (int k = 0; k < 4; k++) check_log(k, 1'b1, 2'b00, 8'h10 + 8'(k), "t3_read_byte");
    tbr = 1'b1;
    wait_log(10, "t3_drain");
    check_log(9, 1'b0, 2'b00, 8'h14, "t3_last_echo");
    step(3);
    check("t3_empty", {29'd0, fifo_count}, 32'd0);

    // T4: read wins over write in the same cycle
    tbr = 1'b0;
    step(1);
    push_rx(8'h55);
    step(6);
    check("t4_hold", {29'd0, fifo_count}, 32'd1);
    acc_log.delete();
    push_rx(8'h66);
    tbr = 1'b1;
    wait_log(2, "t4_pair");
    check_log(0, 1'b1, 2'b00, 8'h66, "t4_read_first");
    check_log(1, 1'b0, 2'b00, 8'h55, "t4_write_next");
    step(6);
    check_log(2, 1'b0, 2'b00, 8'h66, "t4_second_echo");
    check("t4_empty", {29'd0, fifo_count}, 32'd0);

    // T5: reprogram with bytes held in the FIFO
    tbr = 1'b0;
    step(1);
    push_rx(8'hA1);
    push_rx(8'hA2);
    step(8);
    check("t5_hold", {29'd0, fifo_count}, 32'd2);
    acc_log.delete();
    br_cfg = 2'b11;
    wait_cfg(1'b0, "t5_cfg_drop");
    check("t5_kept_a", {29'd0, fifo_count}, 32'd2);
    wait_cfg(1'b1, "t5_cfg_done");
    check("t5_count", acc_log.size(), 32'd2);
    check_log(0, 1'b0, 2'b10, 8'h50, "t5_lo");
    check_log(1, 1'b0, 2'b11, 8'h00, "t5_hi");
    check("t5_kept_b", {29'd0, fifo_count}, 32'd2);
    tbr = 1'b1;
    wait_log(4, "t5_resume");
    step(3);
    check("t5_empty", {29'd0, fifo_count}, 32'd0);

    // T6: reset lands in the middle of a TX write
    tbr = 1'b0;
    step(1);
    push_rx(8'h77);
    step(6);
    check("t6_hold", {29'd0, fifo_count}, 32'd1);
    tbr = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step(1);
        if (iocs && !iorw && ioaddr == 2'b00) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL t6_write_seen: no TX write within 20 cycles");
      end
    end
    rst = 1'b0;
    #1;
    check("t6_iocs", {31'd0, iocs}, 32'd0);
    check("t6_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("t6_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("t6_state", {30'd0, state}, 32'd0);
    exp_q.delete();
    tbr = 1'b0;
    step(2);
    acc_log.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_cfg(1'b1, "t6_cfg_done");
    check_log(0, 1'b0, 2'b10, 8'h50, "t6_lo");
    check_log(1, 1'b0, 2'b11, 8'h00, "t6_hi");

    step(4);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
